// File: rtl/exe_stage_mc.sv
// Execute stage: single-cycle ALU/compare/branch ops, plus iterative mult/div into HI/LO.
// Latency 1 for single-cycle ops, W+1 for mult/div. in_ready drops while mult/div iterates.
module exe_stage_mc #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  instr_in,
  input  logic [W-1:0] rs_val,
  input  logic [W-1:0] rt_val,
  input  logic [W-1:0] imm_ext,
  output logic         out_valid,
  output logic [31:0]  instr_out,
  output logic [W-1:0] alu_result,
  output logic [W-1:0] store_data,
  output logic         branch_taken,
  output logic [W-1:0] hi_out,
  output logic [W-1:0] lo_out
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  acc_q, lsb_q, opd_q, rs_raw_q;
  logic          neg_q, rneg_q, dz_q;

  logic [5:0]    opc, fn;
  logic          take, is_mc, is_sgn;
  logic [W-1:0]  rs_abs, rt_abs;
  logic [W-1:0]  alu_d;
  logic          br_d;
  logic [W:0]    mul_sum, rem_sh, rem_sub;
  logic          qbit;
  logic [W-1:0]  acc_d, lsb_d, hi_d, lo_d;
  logic [2*W-1:0] prod, prod_c;

  assign opc      = instr_in[31:26];
  assign fn       = instr_in[5:0];
  assign in_ready = (state_q == IDLE);
  assign take     = in_valid && in_ready && (instr_in != 32'd0);
  assign is_mc    = (opc == 6'd0) && (fn[5:2] == 4'b0110);
  assign is_sgn   = ~fn[0];
  assign rs_abs   = rs_val[W-1] ? -rs_val : rs_val;
  assign rt_abs   = rt_val[W-1] ? -rt_val : rt_val;

  always_comb begin
    alu_d = alu_result;
    br_d  = 1'b0;
    case (opc)
      6'd0: begin
        case (fn)
          6'h20: alu_d = rs_val + rt_val;
          6'h22: alu_d = rs_val - rt_val;
          6'h24: alu_d = rs_val & rt_val;
          6'h25: alu_d = rs_val | rt_val;
          6'h2A: alu_d = {{(W-1){1'b0}}, ($signed(rs_val) < $signed(rt_val))};
          6'h2B: alu_d = {{(W-1){1'b0}}, (rs_val < rt_val)};
          6'h10: alu_d = hi_out;
          6'h12: alu_d = lo_out;
          default: ;
        endcase
      end
      6'd8, 6'd35, 6'd43: alu_d = rs_val + imm_ext;
      6'd10: alu_d = {{(W-1){1'b0}}, ($signed(rs_val) < $signed(imm_ext))};
      6'd4:  br_d  = (rs_val == rt_val);
      6'd5:  br_d  = (rs_val != rt_val);
      default: ;
    endcase
  end

  // One iteration of shift-add multiply (acc:lsb = partial:multiplier) or restoring divide
  // (acc:lsb = remainder:dividend-shifting-into-quotient).
  always_comb begin
    mul_sum = {1'b0, acc_q} + (lsb_q[0] ? {1'b0, opd_q} : {(W+1){1'b0}});
    rem_sh  = {acc_q, lsb_q[W-1]};
    rem_sub = rem_sh - {1'b0, opd_q};
    qbit    = ~rem_sub[W];
    if (state_q == DIV) begin
      acc_d = qbit ? rem_sub[W-1:0] : rem_sh[W-1:0];
      lsb_d = {lsb_q[W-2:0], qbit};
    end else begin
      acc_d = mul_sum[W:1];
      lsb_d = {mul_sum[0], lsb_q[W-1:1]};
    end
    prod   = {acc_d, lsb_d};
    prod_c = neg_q ? -prod : prod;
    if (state_q == DIV) begin
      if (dz_q) begin
        hi_d = rs_raw_q;
        lo_d = {W{1'b1}};
      end else begin
        hi_d = rneg_q ? -acc_d : acc_d;
        lo_d = neg_q ? -lsb_d : lsb_d;
      end
    end else begin
      hi_d = prod_c[2*W-1:W];
      lo_d = prod_c[W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      lsb_q        <= '0;
      opd_q        <= '0;
      rs_raw_q     <= '0;
      neg_q        <= 1'b0;
      rneg_q       <= 1'b0;
      dz_q         <= 1'b0;
      out_valid    <= 1'b0;
      instr_out    <= '0;
      alu_result   <= '0;
      store_data   <= '0;
      branch_taken <= 1'b0;
      hi_out       <= '0;
      lo_out       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take) begin
            instr_out  <= instr_in;
            store_data <= rt_val;
            if (is_mc) begin
              state_q      <= fn[1] ? DIV : MUL;
              cnt_q        <= '0;
              acc_q        <= '0;
              lsb_q        <= is_sgn ? rs_abs : rs_val;
              opd_q        <= is_sgn ? rt_abs : rt_val;
              neg_q        <= is_sgn && (rs_val[W-1] ^ rt_val[W-1]);
              rneg_q       <= is_sgn && rs_val[W-1];
              dz_q         <= (rt_val == '0);
              rs_raw_q     <= rs_val;
              out_valid    <= 1'b0;
              branch_taken <= 1'b0;
            end else begin
              out_valid    <= 1'b1;
              alu_result   <= alu_d;
              branch_taken <= br_d;
            end
          end else begin
            out_valid    <= 1'b0;
            instr_out    <= '0;
            branch_taken <= 1'b0;
          end
        end
        default: begin
          acc_q <= acc_d;
          lsb_q <= lsb_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hi_out       <= hi_d;
            lo_out       <= lo_d;
            out_valid    <= 1'b1;
            branch_taken <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_exe_stage_mc.sv
// Bench for exe_stage_mc at W=32 (index 0) and W=8 (index 1) against an arithmetic reference model.
module tb_exe_stage_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid [2];
  logic [31:0] instr_in [2], rs_v [2], rt_v [2], imm_v [2];

  logic        rdy0, ov0, br0, rdy1, ov1, br1;
  logic [31:0] io0, alu0, st0, hi0, lo0, io1;
  logic [7:0]  alu1, st1, hi1, lo1;

  logic        in_ready [2], out_valid [2], br_o [2];
  logic [31:0] instr_out [2], alu_o [2], st_o [2], hi_o [2], lo_o [2];

  int total = 0;
  int bad   = 0;

  logic [31:0] m_alu [2], m_st [2], m_hi [2], m_lo [2];

  exe_stage_mc #(.W(32)) u32 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(rdy0),
    .instr_in(instr_in[0]), .rs_val(rs_v[0]), .rt_val(rt_v[0]), .imm_ext(imm_v[0]),
    .out_valid(ov0), .instr_out(io0), .alu_result(alu0), .store_data(st0),
    .branch_taken(br0), .hi_out(hi0), .lo_out(lo0)
  );

  exe_stage_mc #(.W(8)) u8 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(rdy1),
    .instr_in(instr_in[1]), .rs_val(rs_v[1][7:0]), .rt_val(rt_v[1][7:0]), .imm_ext(imm_v[1][7:0]),
    .out_valid(ov1), .instr_out(io1), .alu_result(alu1), .store_data(st1),
    .branch_taken(br1), .hi_out(hi1), .lo_out(lo1)
  );

  always_comb begin
    in_ready[0] = rdy0;  in_ready[1] = rdy1;
    out_valid[0] = ov0;  out_valid[1] = ov1;
    br_o[0] = br0;       br_o[1] = br1;
    instr_out[0] = io0;  instr_out[1] = io1;
    alu_o[0] = alu0;     alu_o[1] = {24'd0, alu1};
    st_o[0] = st0;       st_o[1] = {24'd0, st1};
    hi_o[0] = hi0;       hi_o[1] = {24'd0, hi1};
    lo_o[0] = lo0;       lo_o[1] = {24'd0, lo1};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int wd(int i);
    return (i == 0) ? 32 : 8;
  endfunction

  function automatic logic [31:0] msk(int i);
    return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  // Interpret the low wd(i) bits as a two's-complement number.
  function automatic longint sx(int i, logic [31:0] x);
    longint v;
    v = longint'(x & msk(i));
    if (x[wd(i)-1]) v = v - (longint'(1) <<< wd(i));
    return v;
  endfunction

  function automatic logic [31:0] rtype(logic [5:0] f);
    return {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, f};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [15:0] im);
    return {op, 5'd1, 5'd2, im};
  endfunction

  task automatic model_op(input int i, input logic [31:0] ins, rs, rt, imm, output bit mc, output bit ebr);
    logic [31:0] m, a, b, c;
    logic [5:0] op, f;
    longint p;
    longint unsigned pu;
    m = msk(i); a = rs & m; b = rt & m; c = imm & m;
    op = ins[31:26]; f = ins[5:0];
    mc = 0; ebr = 0;
    m_st[i] = b;
    if (op == 6'd0) begin
      case (f)
        6'h20: m_alu[i] = (a + b) & m;
        6'h22: m_alu[i] = (a - b) & m;
        6'h24: m_alu[i] = a & b;
        6'h25: m_alu[i] = a | b;
        6'h2A: m_alu[i] = (sx(i, a) < sx(i, b)) ? 32'd1 : 32'd0;
        6'h2B: m_alu[i] = (a < b) ? 32'd1 : 32'd0;
        6'h10: m_alu[i] = m_hi[i];
        6'h12: m_alu[i] = m_lo[i];
        6'h18: begin
          mc = 1; p = sx(i, a) * sx(i, b);
          m_hi[i] = 32'(p >>> wd(i)) & m; m_lo[i] = 32'(p) & m;
        end
        6'h19: begin
          mc = 1; pu = 64'(a) * 64'(b);
          m_hi[i] = 32'(pu >> wd(i)) & m; m_lo[i] = 32'(pu) & m;
        end
        6'h1A, 6'h1B: begin
          mc = 1;
          if (b == 0) begin
            m_lo[i] = m; m_hi[i] = a;
          end else if (f == 6'h1A) begin
            m_lo[i] = 32'(sx(i, a) / sx(i, b)) & m;
            m_hi[i] = 32'(sx(i, a) % sx(i, b)) & m;
          end else begin
            m_lo[i] = a / b; m_hi[i] = a % b;
          end
        end
        default: ;
      endcase
    end else begin
      case (op)
        6'd8, 6'd35, 6'd43: m_alu[i] = (a + c) & m;
        6'd10: m_alu[i] = (sx(i, a) < sx(i, c)) ? 32'd1 : 32'd0;
        6'd4:  ebr = (a == b);
        6'd5:  ebr = (a != b);
        default: ;
      endcase
    end
  endtask

  // Called with time at a falling edge; returns at the falling edge where the result is visible.
  task automatic run_op(input int i, input logic [31:0] ins, rs, rt, imm);
    bit mc, ebr;
    int n, low;
    chk("rdy_before", in_ready[i], 1'b1);
    in_valid[i] = 1'b1; instr_in[i] = ins; rs_v[i] = rs; rt_v[i] = rt; imm_v[i] = imm;
    model_op(i, ins, rs, rt, imm, mc, ebr);
    @(posedge clk);
    @(negedge clk);
    if (mc) begin
      n = 0; low = 0;
      while (!out_valid[i] && n < wd(i) + 4) begin
        n++;
        if (!in_ready[i]) low++;
        @(negedge clk);
      end
      chk("mc_latency", n, wd(i));
      chk("mc_rdy_low", low, wd(i));
      chk("mc_rdy_after", in_ready[i], 1'b1);
      chk("mc_hi", hi_o[i], m_hi[i]);
      chk("mc_lo", lo_o[i], m_lo[i]);
    end
    chk("out_valid", out_valid[i], 1'b1);
    chk("alu", alu_o[i], m_alu[i]);
    chk("branch", br_o[i], ebr);
    chk("instr_out", instr_out[i], ins);
    chk("store", st_o[i], m_st[i]);
  endtask

  task automatic bubble(input int i);
    in_valid[i] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("bub_valid", out_valid[i], 1'b0);
    chk("bub_instr", instr_out[i], 32'd0);
    chk("bub_branch", br_o[i], 1'b0);
    chk("bub_alu_hold", alu_o[i], m_alu[i]);
  endtask

  task automatic chk_zero(input int i);
    chk("rst_ready", in_ready[i], 1'b1);
    chk("rst_valid", out_valid[i], 1'b0);
    chk("rst_instr", instr_out[i], 32'd0);
    chk("rst_alu", alu_o[i], 32'd0);
    chk("rst_store", st_o[i], 32'd0);
    chk("rst_branch", br_o[i], 1'b0);
    chk("rst_hi", hi_o[i], 32'd0);
    chk("rst_lo", lo_o[i], 32'd0);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic rnd_run(input int i);
    logic [5:0] ops [20];
    logic [31:0] r, ins;
    int k;
    ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h10, 6'h12, 6'h18, 6'h19,
            6'h1A, 6'h1B, 6'h07, 6'd8, 6'd10, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2};
    k = $urandom_range(0, 19);
    r = $urandom;
    ins = (k < 13) ? rtype(ops[k]) : itype(ops[k], r[15:0]);
    run_op(i, ins, rnd_opnd(), rnd_opnd(), {{16{r[15]}}, r[15:0]});
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; instr_in[i] = '0; rs_v[i] = '0; rt_v[i] = '0; imm_v[i] = '0;
      m_alu[i] = '0; m_st[i] = '0; m_hi[i] = '0; m_lo[i] = '0;
    end
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_zero(0);
    chk_zero(1);
    reset = 1'b0;

    run_op(0, rtype(6'h20), 32'd5, 32'hFFFF_FFF8, 32'd0);
    chk("tp_add", alu_o[0], 32'hFFFF_FFFD);
    run_op(0, rtype(6'h25), 32'h0F, 32'hF0, 32'd0);
    chk("tp_or", alu_o[0], 32'hFF);
    run_op(0, rtype(6'h2A), 32'hFFFF_FFFF, 32'd1, 32'd0);
    chk("tp_slt", alu_o[0], 32'd1);
    run_op(0, rtype(6'h2B), 32'hFFFF_FFFF, 32'd1, 32'd0);
    chk("tp_sltu", alu_o[0], 32'd0);
    run_op(0, itype(6'd4, 16'd2), 32'd3, 32'd3, 32'd2);
    chk("tp_beq", br_o[0], 1'b1);
    run_op(0, itype(6'd5, 16'd2), 32'd3, 32'd3, 32'd2);
    chk("tp_bne", br_o[0], 1'b0);
    bubble(0);

    run_op(0, rtype(6'h18), 32'd7, 32'hFFFF_FFFD, 32'd0);
    chk("tp_mult_hi", hi_o[0], 32'hFFFF_FFFF);
    chk("tp_mult_lo", lo_o[0], 32'hFFFF_FFEB);
    run_op(0, rtype(6'h12), 32'd0, 32'd0, 32'd0);
    chk("tp_mflo", alu_o[0], 32'hFFFF_FFEB);
    run_op(0, rtype(6'h1A), 32'hFFFF_FFF9, 32'd2, 32'd0);
    chk("tp_div_lo", lo_o[0], 32'hFFFF_FFFD);
    chk("tp_div_hi", hi_o[0], 32'hFFFF_FFFF);
    run_op(0, rtype(6'h1B), 32'd7, 32'd0, 32'd0);
    chk("tp_divu0_lo", lo_o[0], 32'hFFFF_FFFF);
    chk("tp_divu0_hi", hi_o[0], 32'd7);
    run_op(0, rtype(6'h1A), 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    chk("tp_ovf_lo", lo_o[0], 32'h8000_0000);
    chk("tp_ovf_hi", hi_o[0], 32'd0);
    run_op(0, rtype(6'h10), 32'd0, 32'd0, 32'd0);
    chk("tp_mfhi", alu_o[0], 32'd0);

    instr_in[0] = rtype(6'h19); rs_v[0] = 32'd12345; rt_v[0] = 32'd6789;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", in_ready[0], 1'b0);
    reset = 1'b1;
    #1;
    chk_zero(0);
    for (int i = 0; i < 2; i++) begin
      m_alu[i] = '0; m_st[i] = '0; m_hi[i] = '0; m_lo[i] = '0;
    end
    in_valid[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_op(0, rtype(6'h20), 32'd1, 32'd2, 32'd0);
    chk("post_rst_add", alu_o[0], 32'd3);
    chk("post_rst_hi", hi_o[0], 32'd0);
    chk("post_rst_lo", lo_o[0], 32'd0);

    repeat (80) rnd_run(0);
    bubble(0);

    run_op(1, rtype(6'h18), 32'd7, 32'hFFFF_FFFD, 32'd0);
    chk("w8_mult_hi", hi_o[1], 32'hFF);
    chk("w8_mult_lo", lo_o[1], 32'hEB);
    run_op(1, rtype(6'h1B), 32'd7, 32'd0, 32'd0);
    chk("w8_divu0_lo", lo_o[1], 32'hFF);
    chk("w8_divu0_hi", hi_o[1], 32'd7);
    repeat (40) rnd_run(1);
    bubble(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
